data_mem_mmio: RTL and testbench

//  Byte-addressable RV32I data memory with memory-mapped UART window. Executes LB/LH/LW/LBU/LHU/SB/SH/SW
//  (rising edge only), flags misaligned accesses, buffers UART TX/RX bytes in FIFOs with valid/ready

---
 rtl/data_mem_mmio_if.sv | 29 ++
 rtl/data_mem_mmio.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_mmio.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mmio_if.sv
// Core MEM-stage request/response and UART byte-stream signals of data_mem_mmio.
// The memory is the slave; the core plus UART side is the master.
interface data_mem_mmio_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              mem_wr;
  logic [2:0]        mem_op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              misalign;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;

  modport master (
    output req_valid, mem_wr, mem_op, addr, wdata, tx_ready, rx_data, rx_valid,
    input  rdata, rdata_valid, misalign, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, mem_wr, mem_op, addr, wdata, tx_ready, rx_data, rx_valid,
    output rdata, rdata_valid, misalign, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_mmio.sv
// RV32I data memory with a memory-mapped UART window: byte RAM, TX/RX byte FIFOs
// and a status register whose overflow flags clear when read.
module data_mem_mmio #(
  parameter int                ADDR_W     = 12,
  parameter int                DEPTH      = 2048,
  parameter string             INIT_FILE  = "",
  parameter logic [ADDR_W-1:0] TX_ADDR    = 12'h400,
  parameter logic [ADDR_W-1:0] RX_ADDR    = 12'h404,
  parameter logic [ADDR_W-1:0] STAT_ADDR  = 12'h408,
  parameter int                FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  data_mem_mmio_if.slave bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] WIN_LO   = 32'(TX_ADDR);
  localparam logic [31:0] WIN_HI   = 32'(STAT_ADDR) + 32'd3;

  typedef enum logic [2:0] {
    OP_B  = 3'd0,
    OP_H  = 3'd1,
    OP_W  = 3'd2,
    OP_BU = 3'd3,
    OP_HU = 3'd4
  } mem_op_t;

  logic [7:0]    ram [DEPTH];
  logic [31:0]   addr_ext;
  logic [AW-1:0] idx;
  logic [7:0]    b0, b1, b2, b3;
  logic          legal, acc, mis, ok, is_load, in_win, in_ram, ram_we;
  logic          tx_push, rx_pop, stat_rd, tx_ovf_set, rx_ovr_set;
  logic          tx_ovf, rx_ovr;
  logic [31:0]   ram_val, load_val;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic [PW:0]   tx_count;
  logic          tx_nonempty, tx_full, tx_do_push, tx_do_pop;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic [PW:0]   rx_count;
  logic          rx_nonempty, rx_full, rx_do_push, rx_do_pop;
  logic [7:0]    rx_head;

  // Illegal ops are ignored outright; misaligned legal ops are rejected but still answered.
  always_comb begin
    addr_ext = 32'(bus.addr);
    idx      = bus.addr[AW-1:0];
    legal    = bus.mem_wr ? (bus.mem_op <= OP_W) : (bus.mem_op <= OP_HU);
    acc      = bus.req_valid & legal;
    mis      = ((bus.mem_op == OP_H || bus.mem_op == OP_HU) && bus.addr[0]) ||
               (bus.mem_op == OP_W && bus.addr[1:0] != 2'b00);
    ok       = acc & ~mis;
    is_load  = ok & ~bus.mem_wr;
    in_win   = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
    in_ram   = !in_win && (addr_ext < 32'(DEPTH));
    ram_we   = ok & bus.mem_wr & in_ram;
    tx_push  = ok & bus.mem_wr & (bus.addr == TX_ADDR);
    rx_pop   = is_load & (bus.addr == RX_ADDR);
    stat_rd  = is_load & (bus.addr == STAT_ADDR);
  end

  always_comb begin
    b0      = ram[idx];
    b1      = ram[idx + AW'(1)];
    b2      = ram[idx + AW'(2)];
    b3      = ram[idx + AW'(3)];
    ram_val = '0;
    case (bus.mem_op)
      OP_B:    ram_val = {{24{b0[7]}}, b0};
      OP_H:    ram_val = {{16{b1[7]}}, b1, b0};
      OP_W:    ram_val = {b3, b2, b1, b0};
      OP_BU:   ram_val = {24'h0, b0};
      OP_HU:   ram_val = {16'h0, b1, b0};
      default: ram_val = '0;
    endcase
    load_val = '0;
    if (in_win) begin
      if (bus.addr == RX_ADDR && rx_nonempty)
        load_val = {23'h0, 1'b1, rx_head};
      else if (bus.addr == STAT_ADDR)
        load_val = {28'h0, rx_ovr, tx_ovf, rx_nonempty, tx_full};
    end else if (in_ram) begin
      load_val = ram_val;
    end
  end

  // A full FIFO overflows only when nothing leaves it on the same edge.
  assign tx_ovf_set = tx_push & tx_full & ~bus.tx_ready;
  assign rx_ovr_set = bus.rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      bus.misalign    <= 1'b0;
      tx_ovf          <= 1'b0;
      rx_ovr          <= 1'b0;
    end else begin
      bus.rdata_valid <= acc & (mis | ~bus.mem_wr);
      bus.misalign    <= acc & mis;
      if (acc & mis)
        bus.rdata <= '0;
      else if (is_load)
        bus.rdata <= load_val;
      tx_ovf <= tx_ovf_set | (tx_ovf & ~stat_rd);
      rx_ovr <= rx_ovr_set | (rx_ovr & ~stat_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      case (bus.mem_op)
        OP_B: ram[idx] <= bus.wdata[7:0];
        OP_H: begin
          ram[idx]          <= bus.wdata[7:0];
          ram[idx + AW'(1)] <= bus.wdata[15:8];
        end
        OP_W: begin
          ram[idx]          <= bus.wdata[7:0];
          ram[idx + AW'(1)] <= bus.wdata[15:8];
          ram[idx + AW'(2)] <= bus.wdata[23:16];
          ram[idx + AW'(3)] <= bus.wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  assign tx_nonempty  = tx_count != '0;
  assign tx_full      = tx_count == CNT_FULL;
  assign tx_do_pop    = bus.tx_ready & tx_nonempty;
  assign tx_do_push   = tx_push & (~tx_full | tx_do_pop);
  assign bus.tx_valid = tx_nonempty;
  assign bus.tx_data  = tx_nonempty ? tx_mem[tx_rd] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_do_push) tx_wr <= tx_wr + 1'b1;
      if (tx_do_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_do_push && !tx_do_pop)
        tx_count <= tx_count + 1'b1;
      else if (tx_do_pop && !tx_do_push)
        tx_count <= tx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr] <= bus.wdata[7:0];
  end

  assign rx_nonempty = rx_count != '0;
  assign rx_full     = rx_count == CNT_FULL;
  assign rx_do_pop   = rx_pop & rx_nonempty;
  assign rx_do_push  = bus.rx_valid & (~rx_full | rx_do_pop);
  assign rx_head     = rx_nonempty ? rx_mem[rx_rd] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_do_push) rx_wr <= rx_wr + 1'b1;
      if (rx_do_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_do_push && !rx_do_pop)
        rx_count <= rx_count + 1'b1;
      else if (rx_do_pop && !rx_do_push)
        rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wr] <= bus.rx_data;
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomised and directed bench for data_mem_mmio: a byte-array/queue reference model
// feeds expected responses to a scoreboard drained by an independent monitor.
module tb_data_mem_mmio;
  localparam logic [11:0] TX_A      = 12'h400;
  localparam logic [11:0] RX_A      = 12'h404;
  localparam logic [11:0] ST_A      = 12'h408;
  localparam int          FD        = 8;
  localparam int          RAM_BYTES = 2048;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] ref_ram [RAM_BYTES];
  logic [7:0] ref_txq [$];
  logic [7:0] ref_rxq [$];
  logic       ref_tx_ovf = 1'b0;
  logic       ref_rx_ovr = 1'b0;
  resp_t      exp_resp [$];
  logic [7:0] exp_tx [$];

  data_mem_mmio_if #(.ADDR_W(12)) bus ();

  data_mem_mmio #(
    .ADDR_W(12), .DEPTH(RAM_BYTES), .INIT_FILE(""), .TX_ADDR(TX_A),
    .RX_ADDR(RX_A), .STAT_ADDR(ST_A), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model works from access sizes, byte lists and queues.
  task automatic applyStimulus(input logic req, input logic wr, input logic [2:0] op,
                               input logic [11:0] a, input logic [31:0] wd,
                               input logic txr, input logic rxv, input logic [7:0] rxd);
    int          nbytes;
    logic        legal, misal, in_win, pop_tx, push_tx, pop_rx, clear_stat;
    logic [31:0] val;
    resp_t       r;
    checkOutput("tx_valid", 32'(bus.tx_valid), 32'(ref_txq.size() != 0));
    legal      = wr ? (op <= 3'd2) : (op <= 3'd4);
    nbytes     = (op == 3'd0 || op == 3'd3) ? 1 : ((op == 3'd1 || op == 3'd4) ? 2 : 4);
    misal      = (int'(a) % nbytes) != 0;
    in_win     = (a >= TX_A) && (a <= ST_A + 12'd3);
    pop_tx     = txr && (ref_txq.size() > 0);
    push_tx    = 1'b0;
    pop_rx     = 1'b0;
    clear_stat = 1'b0;
    val        = '0;
    if (pop_tx) exp_tx.push_back(ref_txq[0]);
    if (req && legal) begin
      if (misal) begin
        r.data = '0;
        r.mis  = 1'b1;
        exp_resp.push_back(r);
      end else if (!wr) begin
        if (in_win) begin
          if (a == RX_A && ref_rxq.size() > 0) begin
            val    = 32'h100 + 32'(ref_rxq[0]);
            pop_rx = 1'b1;
          end else if (a == ST_A) begin
            val = {28'h0, ref_rx_ovr, ref_tx_ovf, 1'(ref_rxq.size() > 0), 1'(ref_txq.size() == FD)};
            clear_stat = 1'b1;
          end
        end else if (int'(a) < RAM_BYTES) begin
          for (int k = 0; k < nbytes; k++) val += 32'(ref_ram[int'(a) + k]) << (8 * k);
          if (op == 3'd0 && val >= 32'd128)   val -= 32'd256;
          if (op == 3'd1 && val >= 32'd32768) val -= 32'd65536;
        end
        r.data = val;
        r.mis  = 1'b0;
        exp_resp.push_back(r);
      end else if (a == TX_A) begin
        push_tx = 1'b1;
      end else if (!in_win && int'(a) < RAM_BYTES) begin
        for (int k = 0; k < nbytes; k++) ref_ram[int'(a) + k] = wd[8 * k +: 8];
      end
    end
    if (clear_stat) begin
      ref_tx_ovf = 1'b0;
      ref_rx_ovr = 1'b0;
    end
    if (pop_tx) void'(ref_txq.pop_front());
    if (push_tx) begin
      if (ref_txq.size() < FD) ref_txq.push_back(wd[7:0]);
      else ref_tx_ovf = 1'b1;
    end
    if (pop_rx) void'(ref_rxq.pop_front());
    if (rxv) begin
      if (ref_rxq.size() < FD) ref_rxq.push_back(rxd);
      else ref_rx_ovr = 1'b1;
    end
    bus.req_valid = req;
    bus.mem_wr    = wr;
    bus.mem_op    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.tx_ready  = txr;
    bus.rx_valid  = rxv;
    bus.rx_data   = rxd;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] op, input logic [11:0] a, input logic txr);
    applyStimulus(1'b1, 1'b0, op, a, 32'h0, txr, 1'b0, 8'h00);
  endtask

  task automatic store(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d, input logic txr);
    applyStimulus(1'b1, 1'b1, op, a, d, txr, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 12'h0, 32'h0, txr, 1'b0, 8'h00);
  endtask

  task automatic rxPulse(input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h0, 32'h0, 1'b0, 1'b1, d);
  endtask

  task automatic resetDut();
    rst = 1'b0;
    #1;
    checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_rdata_valid", 32'(bus.rdata_valid), 32'h0);
    checkOutput("rst_misalign", 32'(bus.misalign), 32'h0);
    ref_txq.delete();
    ref_rxq.delete();
    exp_resp.delete();
    exp_tx.delete();
    ref_tx_ovf = 1'b0;
    ref_rx_ovr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rdata_valid) begin
        if (exp_resp.size() == 0) begin
          checkOutput("unexpected_rdata_valid", 32'(exp_resp.size()), 32'h1);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          checkOutput("rdata", bus.rdata, r.data);
          checkOutput("misalign", 32'(bus.misalign), 32'(r.mis));
        end
      end else if (bus.misalign) begin
        checkOutput("misalign_without_valid", 32'(bus.rdata_valid), 32'h1);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0)
          checkOutput("unexpected_tx_byte", 32'(exp_tx.size()), 32'h1);
        else
          checkOutput("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] a;
    bus.req_valid = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_op    = 3'd0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    #2;
    resetDut();

    for (int w = 0; w < 16; w++) store(3'd2, 12'(w * 4), $urandom, 1'b0);

    store(3'd2, 12'h010, 32'h8000_00F1, 1'b0);
    for (int op = 0; op < 5; op++) load(3'(op), 12'h010, 1'b0);
    load(3'd1, 12'h012, 1'b0);

    load(3'd2, 12'h000, 1'b0);
    load(3'd2, 12'h011, 1'b0);
    store(3'd1, 12'h003, 32'hDEAD_BEEF, 1'b0);
    load(3'd2, 12'h000, 1'b0);
    store(3'd2, 12'h900, 32'h1234_5678, 1'b0);
    load(3'd2, 12'h900, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd6, 12'h010, 32'h0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 3'd3, 12'h010, 32'h0, 1'b0, 1'b0, 8'h00);
    load(3'd2, 12'h010, 1'b0);

    for (int i = 0; i < 9; i++) store(3'd0, TX_A, 32'(8'h41 + i), 1'b0);
    load(3'd2, ST_A, 1'b0);
    load(3'd2, TX_A, 1'b0);
    idle(10, 1'b1);
    load(3'd2, ST_A, 1'b1);

    rxPulse(8'h55);
    rxPulse(8'hAA);
    load(3'd2, ST_A, 1'b0);
    for (int i = 0; i < 3; i++) load(3'd2, RX_A, 1'b0);

    for (int i = 0; i < FD; i++) rxPulse(8'(8'h10 + i));
    applyStimulus(1'b1, 1'b0, 3'd2, RX_A, 32'h0, 1'b0, 1'b1, 8'h99);
    load(3'd2, ST_A, 1'b0);
    rxPulse(8'hEE);
    load(3'd2, ST_A, 1'b0);
    load(3'd2, ST_A, 1'b0);
    for (int i = 0; i < FD + 1; i++) load(3'd0, RX_A, 1'b0);

    for (int i = 0; i < 5; i++) store(3'd2, TX_A, 32'(8'h61 + i), 1'b0);
    idle(2, 1'b1);
    resetDut();
    load(3'd2, ST_A, 1'b0);
    load(3'd2, 12'h010, 1'b0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 12'($urandom_range(0, 63));
        2:       a = TX_A;
        3:       a = RX_A;
        4:       a = ST_A;
        default: a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(12'h800, 12'hFFF))
                                                : 12'($urandom_range(12'h400, 12'h40B));
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0), 8'($urandom));
    end

    idle(FD + 4, 1'b1);
    checkOutput("resp_queue_drained", 32'(exp_resp.size()), 32'h0);
    checkOutput("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
